mdio_phy_manager: RTL and testbench

Management-plane controller for the SGMII Ethernet PHY attached to `gig_eth_pcs_pma`. It sequences the PHY hardware reset on `eth_reset_n`. It then serves single-transaction IEEE 802.3 Clause-22 MDIO read/write requests from a valid/ready command port, generating `eth_mdc` and driving the split `eth_mdio` tristate controls that feed the top-level IOBUF.

---
 rtl/mdio_phy_manager.sv | 188 ++++++++++++++++++
 tb/tb_mdio_phy_manager.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_phy_manager.sv
// rtl/mdio_phy_manager.sv - PHY reset sequencer and Clause-22 MDIO master
// Serves one MDIO read or write per command; sequences eth_reset_n after reset or on request.
module mdio_phy_manager #(
    parameter int CLK_DIV    = 50,
    parameter int RESET_HOLD = 2000,
    parameter int RESET_WAIT = 10000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        phy_rst_req,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        eth_mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i,
    output logic        eth_reset_n,
    output logic        phy_ready
);

    localparam int CNT_MAX = (RESET_HOLD > RESET_WAIT) ? RESET_HOLD : RESET_WAIT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int DW      = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        RST_HOLD,
        RST_WAIT,
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   div_cnt;
    logic            phase;
    logic [5:0]      bit_idx;
    logic [63:0]     frame;
    logic            is_write;
    logic            rst_pend;
    logic [15:0]     rd_shift;
    logic            err_q;

    logic hold_done;
    logic wait_done;
    logic half_end;
    logic bit_end;
    logic frame_end;
    logic accept;
    logic drive;

    assign hold_done = (cnt == CW'(RESET_HOLD - 1));
    assign wait_done = (cnt == CW'(RESET_WAIT - 1));
    assign half_end  = (div_cnt == DW'(CLK_DIV - 1));
    assign bit_end   = phase && half_end;
    assign frame_end = bit_end && (bit_idx == 6'd63);
    assign accept    = cmd_valid && cmd_ready;

    // Reads release the line from the turnaround onward so the PHY can answer.
    assign drive       = (state == SHIFT) && (is_write || (bit_idx < 6'd46));
    assign mdio_t      = !drive;
    assign mdio_o      = drive ? frame[63] : 1'b1;
    assign eth_mdc     = (state == SHIFT) && phase;
    assign eth_reset_n = (state != RST_HOLD);
    assign phy_ready   = (state == IDLE) || (state == SHIFT) || (state == DONE);
    assign cmd_ready   = (state == IDLE) && !phy_rst_req;
    assign rsp_valid   = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RST_HOLD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RST_HOLD: begin
                if (!phy_rst_req && hold_done) begin
                    state_next = RST_WAIT;
                end
            end
            RST_WAIT: begin
                if (phy_rst_req) begin
                    state_next = RST_HOLD;
                end else if (wait_done) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (phy_rst_req) begin
                    state_next = RST_HOLD;
                end else if (cmd_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (frame_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = (rst_pend || phy_rst_req) ? RST_HOLD : IDLE;
            end
            default: state_next = RST_HOLD;
        endcase
    end

    // A reset request restarts the count even when the state itself does not change.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if ((state == RST_HOLD || state == RST_WAIT) && state_next == state && !phy_rst_req) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_pend <= 1'b0;
        end else if (state == DONE) begin
            rst_pend <= 1'b0;
        end else if (state == SHIFT && phy_rst_req) begin
            rst_pend <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt   <= '0;
            phase     <= 1'b0;
            bit_idx   <= '0;
            frame     <= '1;
            is_write  <= 1'b0;
            rd_shift  <= '0;
            err_q     <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            div_cnt  <= '0;
            phase    <= 1'b0;
            bit_idx  <= '0;
            is_write <= cmd_write;
            frame    <= {32'hFFFF_FFFF, 2'b01,
                         cmd_write ? 2'b01 : 2'b10,
                         cmd_phy_addr, cmd_reg_addr,
                         cmd_write ? 2'b10 : 2'b11,
                         cmd_write ? cmd_wdata : 16'hFFFF};
        end else if (state == SHIFT) begin
            if (half_end) begin
                div_cnt <= '0;
                phase   <= ~phase;
                if (phase) begin
                    bit_idx <= bit_idx + 6'd1;
                    frame   <= {frame[62:0], 1'b1};
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (bit_end) begin
                if (bit_idx == 6'd47) begin
                    err_q <= mdio_i;
                end
                if (bit_idx >= 6'd48) begin
                    rd_shift <= {rd_shift[14:0], mdio_i};
                end
            end
            // The final data bit is folded in directly so the response is complete in DONE.
            if (frame_end) begin
                rsp_rdata <= is_write ? 16'h0000 : {rd_shift[14:0], mdio_i};
                rsp_err   <= is_write ? 1'b0 : err_q;
            end
        end
    end

endmodule

// File: tb/tb_mdio_phy_manager.sv
// tb/tb_mdio_phy_manager.sv - scoreboard bench for mdio_phy_manager
module tb_mdio_phy_manager;

    logic        clock = 1'b0;
    logic        reset;
    logic        phy_rst_req;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        eth_mdc;
    logic        mdio_o;
    logic        mdio_t;
    logic        mdio_i = 1'b1;
    logic        eth_reset_n;
    logic        phy_ready;

    int n_checks = 0;
    int n_fail   = 0;
    logic [16:0] exp_q[$];

    logic        phy_present = 1'b0;
    logic [15:0] rd_val = 16'h0000;
    logic [63:0] cap;
    int          bitcnt = 64;
    logic        prev_mdc = 1'b0;

    mdio_phy_manager #(.CLK_DIV(2), .RESET_HOLD(10), .RESET_WAIT(20)) dut (
        .clock(clock), .reset(reset), .phy_rst_req(phy_rst_req),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .eth_mdc(eth_mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i),
        .eth_reset_n(eth_reset_n), .phy_ready(phy_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // PHY model: captures the line on each MDC rise and answers reads.
    always @(negedge clock) begin
        if (cmd_valid && cmd_ready) begin
            bitcnt = 0;
        end
        if (eth_mdc && !prev_mdc && bitcnt < 64) begin
            cap[63 - bitcnt] = mdio_o;
            if (phy_present && bitcnt == 47) begin
                mdio_i = 1'b0;
            end else if (phy_present && bitcnt >= 48) begin
                mdio_i = rd_val[63 - bitcnt];
            end else begin
                mdio_i = 1'b1;
            end
            bitcnt++;
        end
        if (!phy_present || reset) begin
            mdio_i = 1'b1;
        end
        prev_mdc = eth_mdc;
    end

    // Response monitor
    always @(negedge clock) begin
        if (!reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata %0h err %0b expected none", rsp_rdata, rsp_err);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("rsp_rdata", 64'(rsp_rdata), 64'(e[15:0]));
                check("rsp_err", 64'(rsp_err), 64'(e[16]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Entered on the first cycle of RST_HOLD with count 0.
    task automatic reset_seq_check(input string tag);
        int rise_n = -1;
        int rdy_n  = -1;
        int cr_n   = -1;
        int bad    = 0;
        for (int i = 0; i < 45; i++) begin
            if (i > 0) tick();
            if (eth_reset_n && rise_n < 0) rise_n = i;
            if (phy_ready && rdy_n < 0) rdy_n = i;
            if (cmd_ready && cr_n < 0) cr_n = i;
            if (eth_mdc !== 1'b0 || mdio_o !== 1'b1 || mdio_t !== 1'b1 || rsp_valid !== 1'b0) bad++;
        end
        check({tag, "_reset_n_rise"}, 64'(rise_n), 64'd10);
        check({tag, "_phy_ready_rise"}, 64'(rdy_n), 64'd30);
        check({tag, "_cmd_ready_rise"}, 64'(cr_n), 64'd30);
        check({tag, "_idle_outputs"}, 64'(bad), 64'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 300) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic start_cmd(input logic wr, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
        wait_ready();
        cmd_write    = wr;
        cmd_phy_addr = pa;
        cmd_reg_addr = ra;
        cmd_wdata    = wd;
        cmd_valid    = 1'b1;
        tick();
        cmd_valid    = 1'b0;
        cmd_write    = ~wr;
        cmd_phy_addr = 5'h1F;
        cmd_reg_addr = 5'h1F;
        cmd_wdata    = 16'hDEAD;
    endtask

    // Runs a frame from cycle N+1; returns the cycle offset where rsp_valid appeared.
    task automatic run_frame(input logic wr, input int rst_at, output int done_c);
        done_c = -1;
        for (int c = 1; c < 400; c++) begin
            phy_rst_req = (c == rst_at);
            if (!wr && c == 184) check("mdio_t_bit45", 64'(mdio_t), 64'd0);
            if (!wr && c == 185) check("mdio_t_bit46", 64'(mdio_t), 64'd1);
            if (rsp_valid) begin
                done_c = c;
                break;
            end
            tick();
        end
        phy_rst_req = 1'b0;
        check("rsp_latency", 64'(done_c), 64'd257);
    endtask

    initial begin
        int dc;
        reset        = 1'b1;
        phy_rst_req  = 1'b0;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_phy_addr = '0;
        cmd_reg_addr = '0;
        cmd_wdata    = '0;
        tick();
        tick();
        check("rst_outputs", {eth_reset_n, phy_ready, cmd_ready, rsp_valid, eth_mdc, mdio_o, mdio_t},
              7'b0000011);
        check("rst_rsp", {rsp_err, rsp_rdata}, 17'h0);
        reset = 1'b0;
        #1;
        reset_seq_check("por");

        // Write PHY 7 reg 0 data 0x1140
        exp_q.push_back({1'b0, 16'h0000});
        start_cmd(1'b1, 5'd7, 5'd0, 16'h1140);
        run_frame(1'b1, -1, dc);
        check("write_frame", cap, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'b00111, 5'b00000, 2'b10, 16'b0001000101000000});
        tick();
        check("ready_after_write", 64'(cmd_ready), 64'd1);

        // Read PHY 1 reg 2 with a responding PHY
        phy_present = 1'b1;
        rd_val      = 16'h0141;
        exp_q.push_back({1'b0, 16'h0141});
        start_cmd(1'b0, 5'd1, 5'd2, 16'h0000);
        run_frame(1'b0, -1, dc);
        check("read_header", 64'(cap[63:18]), 64'({32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd2}));

        // Read with nothing answering
        phy_present = 1'b0;
        exp_q.push_back({1'b1, 16'hFFFF});
        start_cmd(1'b0, 5'd3, 5'd1, 16'h0000);
        run_frame(1'b0, -1, dc);
        tick();
        check("rsp_hold", {rsp_err, rsp_rdata}, {1'b1, 16'hFFFF});

        // Reset request during bit 20 of a write
        exp_q.push_back({1'b0, 16'h0000});
        start_cmd(1'b1, 5'd4, 5'd9, 16'hA5C3);
        run_frame(1'b1, 81, dc);
        tick();
        check("req_pend_phy_ready", 64'(phy_ready), 64'd0);
        reset_seq_check("req_pend");

        // Command and reset request together in IDLE
        wait_ready();
        cmd_write   = 1'b1;
        cmd_valid   = 1'b1;
        phy_rst_req = 1'b1;
        #1;
        check("simul_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        cmd_valid   = 1'b0;
        phy_rst_req = 1'b0;
        reset_seq_check("simul");

        // Asynchronous reset during bit 20 of a read
        phy_present = 1'b1;
        rd_val      = 16'h1234;
        exp_q.push_back({1'b0, 16'h1234});
        start_cmd(1'b0, 5'd1, 5'd2, 16'h0000);
        repeat (80) tick();
        check("abort_mid_frame_mdio_t", 64'(mdio_t), 64'd0);
        void'(exp_q.pop_back());
        reset = 1'b1;
        #1;
        check("abort_outputs", {eth_reset_n, phy_ready, cmd_ready, rsp_valid, eth_mdc, mdio_o, mdio_t},
              7'b0000011);
        check("abort_rsp", {rsp_err, rsp_rdata}, 17'h0);
        phy_present = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        reset_seq_check("abort");

        repeat (5) tick();
        check("pending_rsp", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
